// File: rtl/player_status_ascii_tx_pkg.sv
// Shared definitions for player_status_ascii_tx: ASCII codes, message ids,
// message lengths and FSM state encoding.
package player_status_ascii_tx_pkg;

  localparam logic [7:0] ASC_R  = 8'h52;
  localparam logic [7:0] ASC_S  = 8'h53;
  localparam logic [7:0] ASC_T  = 8'h54;
  localparam logic [7:0] ASC_P  = 8'h50;
  localparam logic [7:0] ASC_A  = 8'h41;
  localparam logic [7:0] ASC_U  = 8'h55;
  localparam logic [7:0] ASC_E  = 8'h45;
  localparam logic [7:0] ASC_L  = 8'h4C;
  localparam logic [7:0] ASC_Y  = 8'h59;
  localparam logic [7:0] ASC_F  = 8'h46;
  localparam logic [7:0] ASC_W  = 8'h57;
  localparam logic [7:0] ASC_D  = 8'h44;
  localparam logic [7:0] ASC_V  = 8'h56;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_SP = 8'h20;

  typedef logic [2:0] idx_t;

  typedef enum logic [2:0] {
    MSG_RST,
    MSG_PAUSE,
    MSG_PLAY,
    MSG_FWD,
    MSG_REV
  } msg_id_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_TERM,
    ST_GAP
  } state_e;

  localparam idx_t LEN_RST   = 3'd3;
  localparam idx_t LEN_PAUSE = 3'd5;
  localparam idx_t LEN_PLAY  = 3'd4;
  localparam idx_t LEN_FWD   = 3'd3;
  localparam idx_t LEN_REV   = 3'd3;

  function automatic idx_t msg_len(input msg_id_e id);
    case (id)
      MSG_RST:   return LEN_RST;
      MSG_PAUSE: return LEN_PAUSE;
      MSG_PLAY:  return LEN_PLAY;
      MSG_FWD:   return LEN_FWD;
      MSG_REV:   return LEN_REV;
      default:   return LEN_RST;
    endcase
  endfunction

endpackage

// File: rtl/player_status_ascii_tx_status_msg_rom.sv
// status_msg_rom: combinational message text lookup, (msg_id, index) -> ASCII
// byte plus a flag marking the last character of the message.
module status_msg_rom
  import player_status_ascii_tx_pkg::*;
(
  input  msg_id_e    msg_id,
  input  idx_t       index,
  output logic [7:0] ascii,
  output logic       last
);

  always_comb begin
    ascii = ASC_SP;
    case (msg_id)
      MSG_RST: begin
        case (index)
          3'd0: ascii = ASC_R;
          3'd1: ascii = ASC_S;
          3'd2: ascii = ASC_T;
          default: ;
        endcase
      end
      MSG_PAUSE: begin
        case (index)
          3'd0: ascii = ASC_P;
          3'd1: ascii = ASC_A;
          3'd2: ascii = ASC_U;
          3'd3: ascii = ASC_S;
          3'd4: ascii = ASC_E;
          default: ;
        endcase
      end
      MSG_PLAY: begin
        case (index)
          3'd0: ascii = ASC_P;
          3'd1: ascii = ASC_L;
          3'd2: ascii = ASC_A;
          3'd3: ascii = ASC_Y;
          default: ;
        endcase
      end
      MSG_FWD: begin
        case (index)
          3'd0: ascii = ASC_F;
          3'd1: ascii = ASC_W;
          3'd2: ascii = ASC_D;
          default: ;
        endcase
      end
      MSG_REV: begin
        case (index)
          3'd0: ascii = ASC_R;
          3'd1: ascii = ASC_E;
          3'd2: ascii = ASC_V;
          default: ;
        endcase
      end
      default: ;
    endcase
    last = (index == msg_len(msg_id) - 3'd1);
  end

endmodule

// File: rtl/player_status_ascii_tx.sv
// Echoes player flag changes (restart/pause/direction) as ASCII messages on a
// valid/ready byte stream. Define PLAYER_STATUS_CRLF_EN for a CR LF terminator.
module player_status_ascii_tx
  import player_status_ascii_tx_pkg::*;
#(
  parameter int IDLE_GAP = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pause,
  input  logic       play_forward,
  input  logic       restart,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       busy
);

`ifdef PLAYER_STATUS_CRLF_EN
  localparam logic [7:0] TERM_FIRST = ASC_CR;
`else
  localparam logic [7:0] TERM_FIRST = ASC_SP;
`endif

  localparam logic [7:0] GAP_LAST = 8'(IDLE_GAP - 1);

  state_e     state_q, state_d;
  idx_t       idx_q, idx_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  msg_id_e    msg_q, msg_d;
  logic       last_q, last_d;
  logic [7:0] char_data_q, char_data_d;
  logic       char_valid_q, char_valid_d;
  logic       pause_s_q, pause_s_d;
  logic       dir_s_q, dir_s_d;
  logic       restart_d_q, restart_d_d;
  logic       rst_pend_q, rst_pend_d;
  logic       rep_pause_q, rep_pause_d;
  logic       rep_dir_q, rep_dir_d;

  msg_id_e    rom_msg;
  idx_t       rom_idx;
  logic [7:0] rom_ascii;
  logic       rom_last;
  logic       handshake;
  logic       sel_rst;
  logic       term_done;

  status_msg_rom u_rom (
    .msg_id (rom_msg),
    .index  (rom_idx),
    .ascii  (rom_ascii),
    .last   (rom_last)
  );

  // The ROM is always addressed with the byte to be presented next, so
  // char_data can be loaded straight into its output register.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    gap_cnt_d    = gap_cnt_q;
    msg_d        = msg_q;
    last_d       = last_q;
    char_data_d  = char_data_q;
    char_valid_d = char_valid_q;
    rep_pause_d  = rep_pause_q;
    rep_dir_d    = rep_dir_q;
    pause_s_d    = pause;
    dir_s_d      = play_forward;
    restart_d_d  = restart;
    rom_msg      = msg_q;
    rom_idx      = idx_q + 3'd1;
    handshake    = char_valid_q & char_ready;
    sel_rst      = 1'b0;
    term_done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rst_pend_q || (pause_s_q != rep_pause_q) || (dir_s_q != rep_dir_q)) begin
          if (rst_pend_q) begin
            rom_msg = MSG_RST;
            sel_rst = 1'b1;
          end else if (pause_s_q != rep_pause_q) begin
            rom_msg     = pause_s_q ? MSG_PAUSE : MSG_PLAY;
            rep_pause_d = pause_s_q;
          end else begin
            rom_msg   = dir_s_q ? MSG_FWD : MSG_REV;
            rep_dir_d = dir_s_q;
          end
          rom_idx      = '0;
          msg_d        = rom_msg;
          idx_d        = '0;
          char_data_d  = rom_ascii;
          last_d       = rom_last;
          char_valid_d = 1'b1;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (handshake) begin
          if (last_q) begin
            idx_d       = '0;
            char_data_d = TERM_FIRST;
            state_d     = ST_TERM;
          end else begin
            idx_d       = rom_idx;
            char_data_d = rom_ascii;
            last_d      = rom_last;
          end
        end
      end
      ST_TERM: begin
        if (handshake) begin
`ifdef PLAYER_STATUS_CRLF_EN
          if (idx_q == '0) begin
            char_data_d = ASC_LF;
            idx_d       = 3'd1;
          end else begin
            term_done = 1'b1;
          end
`else
          term_done = 1'b1;
`endif
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // GAP holds for exactly IDLE_GAP clocks after the last terminator byte.
    if (term_done) begin
      char_valid_d = 1'b0;
      idx_d        = '0;
      gap_cnt_d    = '0;
      state_d      = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
    end

    // A rising edge coinciding with RST selection re-arms the pending bit.
    rst_pend_d = (rst_pend_q & ~sel_rst) | (restart & ~restart_d_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      gap_cnt_q    <= '0;
      msg_q        <= MSG_RST;
      last_q       <= 1'b0;
      char_data_q  <= 8'h00;
      char_valid_q <= 1'b0;
      pause_s_q    <= 1'b1;
      dir_s_q      <= 1'b1;
      restart_d_q  <= 1'b0;
      rst_pend_q   <= 1'b0;
      rep_pause_q  <= 1'b1;
      rep_dir_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_cnt_q    <= gap_cnt_d;
      msg_q        <= msg_d;
      last_q       <= last_d;
      char_data_q  <= char_data_d;
      char_valid_q <= char_valid_d;
      pause_s_q    <= pause_s_d;
      dir_s_q      <= dir_s_d;
      restart_d_q  <= restart_d_d;
      rst_pend_q   <= rst_pend_d;
      rep_pause_q  <= rep_pause_d;
      rep_dir_q    <= rep_dir_d;
    end
  end

  assign char_data  = char_data_q;
  assign char_valid = char_valid_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_player_status_ascii_tx.sv
// Scoreboard bench for player_status_ascii_tx: a message-level reference model
// queues expected bytes, a negedge monitor pops and compares every transfer.
module tb_player_status_ascii_tx;

  localparam int IDLE_GAP = 3;
`ifdef PLAYER_STATUS_CRLF_EN
  localparam int TERM_N = 2;
`else
  localparam int TERM_N = 1;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       pause;
  logic       play_forward;
  logic       restart;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic       busy;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_popped = 0;

  player_status_ascii_tx #(.IDLE_GAP(IDLE_GAP)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pause        (pause),
    .play_forward (play_forward),
    .restart      (restart),
    .char_data    (char_data),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (message level) ----------------
  bit m_pause_s, m_dir_s, m_rest_prev, m_rst_pend, m_rep_pause, m_rep_dir;
  int m_left, m_gap;

  task automatic push_byte(input logic [7:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic push_msg(input string s);
    for (int i = 0; i < s.len(); i++) push_byte(s[i], 1'b0);
`ifdef PLAYER_STATUS_CRLF_EN
    push_byte(8'h0D, 1'b0);
    push_byte(8'h0A, 1'b1);
`else
    push_byte(8'h20, 1'b1);
`endif
    m_left = s.len() + TERM_N;
  endtask

  task automatic model_reset();
    m_pause_s = 1; m_dir_s = 1; m_rest_prev = 0; m_rst_pend = 0;
    m_rep_pause = 1; m_rep_dir = 1; m_left = 0; m_gap = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit idle, sel_rst;
    idle    = (m_left == 0) && (m_gap == 0);
    sel_rst = 0;
    if (m_left > 0) begin
      if (char_ready) begin
        m_left--;
        if (m_left == 0) m_gap = IDLE_GAP;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end
    if (idle) begin
      if (m_rst_pend) begin
        push_msg("RST");
        sel_rst = 1;
      end else if (m_pause_s != m_rep_pause) begin
        m_rep_pause = m_pause_s;
        if (m_pause_s) push_msg("PAUSE"); else push_msg("PLAY");
      end else if (m_dir_s != m_rep_dir) begin
        m_rep_dir = m_dir_s;
        if (m_dir_s) push_msg("FWD"); else push_msg("REV");
      end
    end
    m_rst_pend  = (m_rst_pend && !sel_rst) || (restart && !m_rest_prev);
    m_rest_prev = restart;
    m_pause_s   = pause;
    m_dir_s     = play_forward;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    bit         hold_pend = 0;
    logic [7:0] hold_data = '0;
    bit         gap_active = 0;
    int         gap_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_pend  = 0;
        gap_active = 0;
      end else begin
        if (hold_pend) check("hold_stable", {char_valid, char_data}, {1'b1, hold_data});
        hold_pend = char_valid && !char_ready;
        hold_data = char_data;
        if (gap_active) begin
          if (busy && !char_valid) gap_cnt++;
          else begin
            check("idle_gap", gap_cnt, IDLE_GAP);
            gap_active = 0;
          end
        end
        if (char_valid && char_ready) begin
          check("byte_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_popped++;
            check("byte_data", char_data, e.data);
            if (e.last) begin
              gap_active = 1;
              gap_cnt    = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int quiet = 0;
    for (int i = 0; i < 3000 && quiet < IDLE_GAP + 6; i++) begin
      tick();
      if (!busy && exp_q.size() == 0) quiet++;
      else quiet = 0;
    end
    check("drain_done", quiet >= IDLE_GAP + 6, 1);
  endtask

  task automatic wait_byte(input logic [7:0] b, input string name);
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (char_valid && char_data == b) found = 1;
    end
    check(name, found, 1);
  endtask

  initial begin
    int lat, n, popped0, nvalid;
    bit seen;
    reset_n = 0; pause = 1; play_forward = 1; restart = 0; char_ready = 1;
    #12;
    check("rst_valid", char_valid, 0);
    check("rst_data", char_data, 8'h00);
    check("rst_busy", busy, 0);
    repeat (2) tick();
    reset_n = 1;

    // Quiet after reset: flags equal the reported reset values.
    nvalid = 0;
    repeat (100) begin tick(); if (char_valid) nvalid++; end
    check("no_msg_after_reset", nvalid, 0);

    // PLAY: latency and back-to-back burst.
    pause = 0;
    lat = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(); lat++;
      if (char_valid) seen = 1;
    end
    check("play_latency", lat, 2);
    check("play_first", char_data, 8'h50);
    n = 1;
    for (int i = 0; i < 20 && char_valid; i++) begin
      tick();
      if (char_valid) n++;
    end
    check("play_burst_len", n, 4 + TERM_N);
    drain();

    // PAUSE with back-pressure on 'U'.
    pause = 1;
    wait_byte(8'h55, "pause_u_seen");
    char_ready = 0;
    repeat (5) begin
      tick();
      check("hold_u", {char_valid, char_data}, {1'b1, 8'h55});
    end
    char_ready = 1;
    tick();
    check("resume_s", {char_valid, char_data}, {1'b1, 8'h53});
    drain();

    // Restart pulse and direction change on the same edge: RST then REV.
    restart = 1; play_forward = 0;
    tick();
    restart = 0;
    drain();

    // Pause toggles and returns while a message is active: only RST appears.
    popped0 = n_popped;
    restart = 1;
    tick();
    restart = 0;
    for (int i = 0; i < 20 && !busy; i++) tick();
    pause = 0;
    tick();
    pause = 1;
    drain();
    check("toggle_no_msg", n_popped - popped0, 3 + TERM_N);

    // Two pending events: restart and pause together (gap checked by monitor).
    popped0 = n_popped;
    restart = 1; pause = 0;
    tick();
    restart = 0;
    drain();
    check("two_msgs", n_popped - popped0, 3 + 4 + 2 * TERM_N);

    // Randomised flags and back-pressure.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      if ($urandom_range(0, 9) == 0) play_forward = ~play_forward;
      restart    = ($urandom_range(0, 11) == 0);
      char_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    restart = 0; char_ready = 1;
    drain();

    // Reset asserted in the middle of "FWD".
    pause = 1; play_forward = 0;
    drain();
    play_forward = 1;
    wait_byte(8'h46, "fwd_f_seen");
    reset_n = 0;
    #1;
    check("abort_valid", char_valid, 0);
    check("abort_busy", busy, 0);
    repeat (3) tick();
    reset_n = 1;
    nvalid = 0;
    repeat (50) begin tick(); if (char_valid) nvalid++; end
    check("no_resume", nvalid, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
